// File: rtl/mppt_pkg.sv
// Shared types and default widths for the perturb-and-observe MPPT sequencer.
//   state_e : tracking loop states
//   dir_e   : duty perturbation direction
package mppt_pkg;

  localparam int unsigned ADC_W_DEF  = 10;
  localparam int unsigned DUTY_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_SETTLE  = 3'd4
  } state_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/mppt_po_sequencer_if.sv
// Sample/duty handshake bundle for mppt_po_sequencer.
//   master : drives enable, adc_done, v_in, i_in; observes the sequencer outputs
//   slave  : the sequencer side (adc_start, duty, duty_valid, busy, adc_err out)
interface mppt_po_sequencer_if #(
  parameter int unsigned ADC_W  = 10,
  parameter int unsigned DUTY_W = 10
) ();

  logic              enable;
  logic              adc_done;
  logic [ADC_W-1:0]  v_in;
  logic [ADC_W-1:0]  i_in;
  logic              adc_start;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              busy;
  logic              adc_err;

  modport master (
    output enable, adc_done, v_in, i_in,
    input  adc_start, duty, duty_valid, busy, adc_err
  );

  modport slave (
    input  enable, adc_done, v_in, i_in,
    output adc_start, duty, duty_valid, busy, adc_err
  );

endinterface

// File: rtl/mppt_cnt.sv
// Up-counter shared by the settle wait and the ADC watchdog.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   limit      : number of counted cycles in one period
//   tc_c       : combinational terminal count, high while count == limit-1
module mppt_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + W'(1);
  end

  assign tc_c = (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/mppt_po_sequencer.sv
// Perturb-and-observe MPPT sequencer: requests an ADC conversion, multiplies
// v*i, steps the PWM duty toward rising power, then waits for the converter
// to settle before the next sample.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of mppt_po_sequencer_if (enable, adc_done, v_in,
//                i_in in; adc_start, duty, duty_valid, busy, adc_err out)
// Optional feature: define MPPT_TIMEOUT_EN to enable the ADC watchdog
// (TIMEOUT_CYCLES without adc_done sets sticky adc_err and re-requests).
module mppt_po_sequencer
  import mppt_pkg::*;
#(
  parameter int unsigned ADC_W          = ADC_W_DEF,
  parameter int unsigned DUTY_W         = DUTY_W_DEF,
  parameter int unsigned DUTY_INIT      = 512,
  parameter int unsigned DUTY_MIN       = 32,
  parameter int unsigned DUTY_MAX       = 992,
  parameter int unsigned STEP           = 4,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                rst_n,
  mppt_po_sequencer_if.slave bus
);

  localparam int unsigned P_W     = 2 * ADC_W;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
`ifdef MPPT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d, dir_sel;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [P_W-1:0]    p_q, p_d, p_prev_q, p_prev_d;
  logic [ADC_W-1:0]  v_q, v_d, i_q, i_d;
  logic              adc_start_q, adc_start_d;
  logic              duty_valid_q, duty_valid_d;
  logic              busy_q, busy_d;
  logic              adc_err_q, adc_err_d;

  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_limit;
  logic [DUTY_W:0]   duty_up;
  logic              duty_up_clamp;
  logic              duty_dn_clamp;
  logic [DUTY_W-1:0] duty_dn;

  // One counter serves both waits; the active state picks its period.
  assign cnt_limit = (state_q == ST_SETTLE) ? CNT_W'(SETTLE_CYCLES) : CNT_W'(TIMEOUT_CYCLES);

  mppt_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .tc_c  (cnt_tc)
  );

  // Extra bit keeps the upward step from wrapping before the clamp compare.
  assign duty_up       = {1'b0, duty_q} + (DUTY_W+1)'(STEP);
  assign duty_up_clamp = (duty_up >= (DUTY_W+1)'(DUTY_MAX));
  assign duty_dn_clamp = ({1'b0, duty_q} <= (DUTY_W+1)'(DUTY_MIN + STEP));
  assign duty_dn       = duty_q - DUTY_W'(STEP);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      duty_q       <= DUTY_W'(DUTY_INIT);
      p_q          <= '0;
      p_prev_q     <= '0;
      v_q          <= '0;
      i_q          <= '0;
      adc_start_q  <= 1'b0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      adc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      duty_q       <= duty_d;
      p_q          <= p_d;
      p_prev_q     <= p_prev_d;
      v_q          <= v_d;
      i_q          <= i_d;
      adc_start_q  <= adc_start_d;
      duty_valid_q <= duty_valid_d;
      busy_q       <= busy_d;
      adc_err_q    <= adc_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    dir_sel      = dir_q;
    duty_d       = duty_q;
    p_d          = p_q;
    p_prev_d     = p_prev_q;
    v_d          = v_q;
    i_d          = i_q;
    adc_start_d  = 1'b0;
    duty_valid_d = 1'b0;
    adc_err_d    = adc_err_q;
    cnt_clr      = 1'b1;
    cnt_en       = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SAMPLE;
          adc_start_d = 1'b1;
        end
        ST_SAMPLE: begin
          // adc_done coinciding with the request cycle belongs to no request.
          if (bus.adc_done && !adc_start_q) begin
            v_d     = bus.v_in;
            i_d     = bus.i_in;
            state_d = ST_COMPUTE;
          end else if (TMO_EN && cnt_tc) begin
            adc_err_d   = 1'b1;
            adc_start_d = 1'b1;
          end else begin
            cnt_clr = 1'b0;
            cnt_en  = TMO_EN;
          end
        end
        ST_COMPUTE: begin
          p_d     = P_W'(v_q) * P_W'(i_q);
          state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          // Ties keep direction so a flat power curve keeps walking.
          if (p_q < p_prev_q) dir_sel = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          p_prev_d = p_q;
          if (dir_sel == DIR_UP) begin
            duty_d = duty_up_clamp ? DUTY_W'(DUTY_MAX) : duty_up[DUTY_W-1:0];
            dir_d  = duty_up_clamp ? DIR_DOWN : DIR_UP;
          end else begin
            duty_d = duty_dn_clamp ? DUTY_W'(DUTY_MIN) : duty_dn;
            dir_d  = duty_dn_clamp ? DIR_UP : DIR_DOWN;
          end
          duty_valid_d = 1'b1;
          state_d      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_tc) begin
            state_d     = ST_SAMPLE;
            adc_start_d = 1'b1;
          end else begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.adc_start  = adc_start_q;
  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.busy       = busy_q;
  assign bus.adc_err    = adc_err_q;

endmodule

// File: tb/tb_mppt_po_sequencer.sv
// Self-checking bench for mppt_po_sequencer: directed P&O scenarios plus
// randomized samples against a behavioural tracking model.
module tb_mppt_po_sequencer;

  localparam int SETTLE   = 1000;
  localparam int TMO      = 255;
  localparam int DUTY_MIN = 32;
  localparam int DUTY_MAX = 992;
  localparam int STEP     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mppt_po_sequencer_if #(.ADC_W(10), .DUTY_W(10)) bus  ();
  mppt_po_sequencer_if #(.ADC_W(10), .DUTY_W(10)) bus2 ();

  mppt_po_sequencer #(
    .ADC_W(10), .DUTY_W(10), .DUTY_INIT(512), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .STEP(STEP), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  mppt_po_sequencer #(
    .ADC_W(10), .DUTY_W(10), .DUTY_INIT(990), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .STEP(STEP), .SETTLE_CYCLES(6), .TIMEOUT_CYCLES(TMO)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_checks = 0;
  int n_pass   = 0;

  // Tracking model state for dut
  int    m_duty;
  bit    m_up;
  longint m_pprev;

  // One P&O decision from the rules: compare power, step, saturate, bounce.
  function automatic void model_step(inout int duty, inout bit up, inout longint pprev,
                                     input int v, input int i);
    longint p;
    p = longint'(v) * longint'(i);
    if (p < pprev) up = !up;
    pprev = p;
    if (up) begin
      duty = duty + STEP;
      if (duty >= DUTY_MAX) begin duty = DUTY_MAX; up = 1'b0; end
    end else begin
      duty = duty - STEP;
      if (duty <= DUTY_MIN) begin duty = DUTY_MIN; up = 1'b1; end
    end
  endfunction

  // Waits for adc_start, answers gap cycles later, reports latency and duty.
  task automatic do_sample(input int v, input int i, input int gap, input bit spur,
                           output bit got_start, output int lat, output int duty_obs);
    got_start = 1'b0;
    lat       = -1;
    duty_obs  = -1;
    for (int k = 0; k < SETTLE + 20; k++) begin
      if (bus.adc_start === 1'b1) begin got_start = 1'b1; break; end
      @(negedge clk);
    end
    if (!got_start) return;
    if (spur) begin
      bus.adc_done = 1'b1;
      bus.v_in     = 10'($urandom);
      bus.i_in     = 10'($urandom);
    end
    repeat (gap) begin
      @(negedge clk);
      bus.adc_done = 1'b0;
    end
    bus.adc_done = 1'b1;
    bus.v_in     = 10'(v);
    bus.i_in     = 10'(i);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.adc_done = 1'b0;
      bus.v_in     = 10'($urandom);
      bus.i_in     = 10'($urandom);
      if (bus.duty_valid === 1'b1) begin
        lat      = k;
        duty_obs = int'(bus.duty);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;  bus.adc_done = 1'b0;  bus.v_in = '0;  bus.i_in = '0;
    bus2.enable = 1'b0; bus2.adc_done = 1'b0; bus2.v_in = '0; bus2.i_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.duty !== 10'd512) $display("FAIL reset_duty: got %0d want 512", bus.duty);
    else n_pass++;
    n_checks++;
    if ({bus.adc_start, bus.duty_valid, bus.busy, bus.adc_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000",
               {bus.adc_start, bus.duty_valid, bus.busy, bus.adc_err});
    else n_pass++;
    n_checks++;
    if (bus2.duty !== 10'd990) $display("FAIL reset_duty2: got %0d want 990", bus2.duty);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    m_duty = 512; m_up = 1'b1; m_pprev = 0;
  endtask

  task automatic test_first_step();
    bit got; int lat, d, n; bit busy_ok, dv_extra;
    bus.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.adc_start !== 1'b1) $display("FAIL first_start: got %b want 1", bus.adc_start);
    else n_pass++;
    do_sample(100, 50, 2, 1'b0, got, lat, d);
    model_step(m_duty, m_up, m_pprev, 100, 50);
    n_checks++;
    if (lat !== 3) $display("FAIL first_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (d !== m_duty) $display("FAIL first_duty: got %0d want %0d", d, m_duty);
    else n_pass++;
    n = 0; busy_ok = 1'b1; dv_extra = 1'b0;
    while (bus.adc_start !== 1'b1 && n < SETTLE + 10) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
      if (bus.duty_valid === 1'b1) dv_extra = 1'b1;
    end
    n_checks++;
    if (n !== SETTLE) $display("FAIL settle_length: got %0d want %0d", n, SETTLE);
    else n_pass++;
    n_checks++;
    if (!busy_ok || dv_extra) $display("FAIL settle_flags: busy_ok %b extra_valid %b want 1 0", busy_ok, dv_extra);
    else n_pass++;
  endtask

  task automatic test_lower_power();
    bit got; int lat, d;
    do_sample(100, 40, 3, 1'b1, got, lat, d);
    model_step(m_duty, m_up, m_pprev, 100, 40);
    n_checks++;
    if (lat !== 3 || d !== m_duty || m_duty != 512)
      $display("FAIL lower_power: got lat %0d duty %0d want lat 3 duty 512", lat, d);
    else n_pass++;
  endtask

  task automatic test_equal_power();
    bit got; int lat, d;
    do_sample(200, 20, 1, 1'b0, got, lat, d);
    model_step(m_duty, m_up, m_pprev, 200, 20);
    n_checks++;
    if (lat !== 3 || d !== m_duty || m_duty != 508)
      $display("FAIL equal_power: got lat %0d duty %0d want lat 3 duty 508", lat, d);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit got, pulse; int lat, d; logic [9:0] held;
    repeat (5) @(negedge clk);
    held = bus.duty;
    bus.enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL drop_idle: got busy %b want 0", bus.busy);
    else n_pass++;
    pulse = 1'b0;
    repeat (20) begin
      if (bus.adc_start !== 1'b0 || bus.duty_valid !== 1'b0 || bus.duty !== held) pulse = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (pulse || held !== 10'(m_duty)) $display("FAIL drop_hold: got duty %0d glitch %b want %0d 0", bus.duty, pulse, m_duty);
    else n_pass++;
    bus.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.adc_start !== 1'b1) $display("FAIL reenable_start: got %b want 1", bus.adc_start);
    else n_pass++;
    do_sample(300, 30, 2, 1'b1, got, lat, d);
    model_step(m_duty, m_up, m_pprev, 300, 30);
    n_checks++;
    if (lat !== 3 || d !== m_duty)
      $display("FAIL reenable_step: got lat %0d duty %0d want 3 %0d", lat, d, m_duty);
    else n_pass++;
  endtask

  task automatic test_random();
    bit got; int lat, d, v, i, pv, pi, mode, t;
    pv = 300; pi = 30;
    for (int r = 0; r < 20; r++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      begin v = pv; i = pi; end
      else if (mode == 1) begin v = pi; i = pv; end
      else begin v = int'($urandom_range(0, 1023)); i = int'($urandom_range(0, 1023)); end
      do_sample(v, i, int'($urandom_range(1, 10)), 1'($urandom), got, lat, d);
      model_step(m_duty, m_up, m_pprev, v, i);
      n_checks++;
      if (!got || lat !== 3) $display("FAIL rand_latency[%0d]: got start %b lat %0d want 1 3", r, got, lat);
      else n_pass++;
      n_checks++;
      if (d !== m_duty) $display("FAIL rand_duty[%0d]: got %0d want %0d (v %0d i %0d)", r, d, m_duty, v, i);
      else n_pass++;
      t = pv; pv = v; pi = i; t = t + 0;
    end
  endtask

  task automatic test_timeout();
`ifdef MPPT_TIMEOUT_EN
    bit got; int lat, d, n;
    for (int k = 0; k < SETTLE + 20 && bus.adc_start !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (bus.adc_err !== 1'b0 || bus.adc_start !== 1'b1)
      $display("FAIL tmo_pre: got err %b start %b want 0 1", bus.adc_err, bus.adc_start);
    else n_pass++;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.adc_start !== 1'b1 && n < TMO + 20);
    n_checks++;
    if (n !== TMO || bus.adc_err !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL tmo_restart: got wait %0d err %b busy %b want %0d 1 1", n, bus.adc_err, bus.busy, TMO);
    else n_pass++;
    do_sample(150, 60, 4, 1'b0, got, lat, d);
    model_step(m_duty, m_up, m_pprev, 150, 60);
    n_checks++;
    if (lat !== 3 || d !== m_duty || bus.adc_err !== 1'b1)
      $display("FAIL tmo_recover: got lat %0d duty %0d err %b want 3 %0d 1", lat, d, bus.adc_err, m_duty);
    else n_pass++;
`else
    n_checks++;
    if (bus.adc_err !== 1'b0) $display("FAIL adc_err_tied: got %b want 0", bus.adc_err);
    else n_pass++;
`endif
  endtask

  task automatic test_clamp();
    int d2; bit up2; longint pp2; int lat; bit got;
    int vs[3]; int is[3];
    vs = '{10, 20, 5}; is = '{10, 10, 5};
    d2 = 990; up2 = 1'b1; pp2 = 0;
    bus2.enable = 1'b1;
    for (int s = 0; s < 3; s++) begin
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus2.adc_start === 1'b1) begin got = 1'b1; break; end
      end
      @(negedge clk);
      bus2.adc_done = 1'b1; bus2.v_in = 10'(vs[s]); bus2.i_in = 10'(is[s]);
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        bus2.adc_done = 1'b0;
        if (bus2.duty_valid === 1'b1) begin lat = k; break; end
      end
      model_step(d2, up2, pp2, vs[s], is[s]);
      n_checks++;
      if (!got || lat !== 3 || bus2.duty !== 10'(d2))
        $display("FAIL clamp_step[%0d]: got start %b lat %0d duty %0d want 1 3 %0d", s, got, lat, bus2.duty, d2);
      else n_pass++;
    end
    bus2.enable = 1'b0;
  endtask

  task automatic test_async_reset();
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.duty !== 10'd512 || bus.busy !== 1'b0 || bus.adc_err !== 1'b0 || bus2.duty !== 10'd990)
      $display("FAIL async_reset: got duty %0d busy %b err %b duty2 %0d want 512 0 0 990",
               bus.duty, bus.busy, bus.adc_err, bus2.duty);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_step();
    test_lower_power();
    test_equal_power();
    test_enable_drop();
    test_random();
    test_timeout();
    test_clamp();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mppt_po_sequencer.md
MPPT_PO_SEQUENCER -- requirements
Module: mppt_po_sequencer

Interface
REQ-001 The block SHALL have parameter ADC_W, default 10, meaning voltage/current sample width.
REQ-002 The block SHALL have parameter DUTY_W, default 10, meaning PWM duty word width.
REQ-003 The block SHALL have parameters DUTY_INIT 512, DUTY_MIN 32, DUTY_MAX 992 and STEP 4, meaning duty reset value, duty clamp limits and perturbation step.
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 1000, meaning converter settle time after each duty update.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning ADC watchdog limit (used only with MPPT_TIMEOUT_EN).
REQ-006 The block SHALL have ports clk, input, 1, the single clock; rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports enable, input, 1, run tracking loop; adc_done, input, 1, conversion complete with v_in/i_in valid.
REQ-008 The block SHALL have ports v_in, input, ADC_W, panel voltage; i_in, input, ADC_W, panel current.
REQ-009 The block SHALL have ports adc_start, output, 1, one-cycle conversion request; duty, output, DUTY_W, registered duty word; duty_valid, output, 1, one-cycle update strobe.
REQ-010 The block SHALL have ports busy, output, 1, high when not IDLE; adc_err, output, 1, sticky ADC timeout flag.

Function
REQ-011 The FSM SHALL have states IDLE, SAMPLE, COMPUTE, DECIDE, SETTLE.
REQ-012 IDLE SHALL go to SAMPLE on the clock edge where enable=1; adc_start SHALL be 1 for exactly the first SAMPLE cycle.
REQ-013 SAMPLE SHALL capture v_in and i_in, then go to COMPUTE, on adc_done=1 in any SAMPLE cycle after the adc_start cycle; adc_done in other states or cycles SHALL be ignored.
REQ-014 COMPUTE SHALL register p = v*i at full 2*ADC_W width, unsigned, in one cycle, then go to DECIDE.
REQ-015 DECIDE SHALL keep direction when p >= p_prev, including ties, and invert it when p < p_prev; it SHALL then set p_prev = p.
REQ-016 DECIDE SHALL set duty = duty +/- STEP by direction, saturating at DUTY_MAX/DUTY_MIN, and SHALL invert direction when the clamp is hit.
REQ-017 DECIDE SHALL pulse duty_valid in the same cycle the new duty becomes visible on the output, then go to SETTLE.
REQ-018 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles, counted by a cleared settle counter, then go to SAMPLE.
REQ-019 Latency SHALL be: adc_done at cycle t gives the new duty and duty_valid at t+3.
REQ-020 enable=0 in any state SHALL return the FSM to IDLE on the next edge without pulses, keeping duty, direction and p_prev.
REQ-021 The first decision after reset SHALL see p_prev=0 and therefore step duty up.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE, duty=DUTY_INIT, direction=up, p_prev=0, settle/timeout counters=0, and adc_start=duty_valid=busy=adc_err=0.

Configuration
REQ-023 With MPPT_TIMEOUT_EN defined, a SAMPLE wait of TIMEOUT_CYCLES cycles without adc_done SHALL set adc_err and restart SAMPLE with a fresh adc_start; adc_err SHALL clear only on reset.
REQ-024 Without MPPT_TIMEOUT_EN, SAMPLE SHALL wait indefinitely, and adc_err SHALL be tied to 0.

Structure
REQ-025 A shared package mppt_pkg SHALL hold the state enum, the direction type and default width constants.
REQ-026 The settle and timeout counting SHALL use one sub-module, mppt_cnt, with a synchronous clear, an enable and a terminal-count flag.

Verification
REQ-027 The bench SHALL apply reset, then enable=1 with adc_done 2 cycles after adc_start, v=100, i=50 -> duty 516 with duty_valid at t+3, then busy held for 1000 SETTLE cycles.
REQ-028 The bench SHALL make the second sample give a lower power (v=100, i=40) -> direction inverts and duty returns to 512.
REQ-029 The bench SHALL apply equal power on consecutive samples -> direction is kept and duty advances by 4.
REQ-030 The bench SHALL preload duty 990 going up with a rising power -> duty clamps to 992 and the next step goes down to 988.
REQ-031 The bench SHALL drop enable in SETTLE and later raise it again -> IDLE the next cycle, duty is unchanged and the next adc_start occurs 1 cycle after enable rises.
REQ-032 With MPPT_TIMEOUT_EN, the bench SHALL withhold adc_done for 255 cycles -> adc_err=1 and adc_start re-pulses; a later adc_done completes the cycle normally.
